// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: bus width, op and state encodings.
package mult_div_unit_pkg;

    localparam int unsigned DATA_BUS = 32;

    typedef enum logic [1:0] {
        MD_OP_MULT  = 2'b00,
        MD_OP_MULTU = 2'b01,
        MD_OP_DIV   = 2'b10,
        MD_OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

endpackage

// File: rtl/mult_div_unit_div_iter.sv
// Radix-2 restoring divider datapath: unsigned magnitudes, one quotient bit per step.
module mult_div_unit_div_iter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              init,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quot_nxt_c,
    output logic [DATA_W-1:0] rem_nxt_c,
    output logic              last_c
);

    localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quot_q;
    logic [DATA_W-1:0] div_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;

    // Trial subtraction; borrow out of the top bit means restore the shifted remainder.
    always_comb begin
        shifted = {rem_q, quot_q[DATA_W-1]};
        trial   = shifted - {1'b0, div_q};
        if (!trial[DATA_W]) begin
            rem_nxt_c  = trial[DATA_W-1:0];
            quot_nxt_c = {quot_q[DATA_W-2:0], 1'b1};
        end else begin
            rem_nxt_c  = shifted[DATA_W-1:0];
            quot_nxt_c = {quot_q[DATA_W-2:0], 1'b0};
        end
    end

    assign last_c = (cnt_q == CNT_W'(DIV_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (init) begin
            rem_q  <= '0;
            quot_q <= dividend;
            div_q  <= divisor;
            cnt_q  <= '0;
        end else if (step) begin
            rem_q  <= rem_nxt_c;
            quot_q <= quot_nxt_c;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit producing the HI/LO pair; stalls the pipeline while busy.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_BUS,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              stall_req,
    output logic              done,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    md_state_e         state, next_state;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              accept, div_zero, div_init, div_step;
    logic              div_signed_in;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W-1:0] quot_nxt, rem_nxt, quot_fix, rem_fix;
    logic              div_last, neg_q, neg_r;
    logic [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] sa, sb;
    logic [PROD_W-1:0] ua, ub;

    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else     state <= next_state;
    end

    // Next state and control strobes; flush overrides everything except the busy stall.
    always_comb begin
        next_state = state;
        stall_req  = 1'b0;
        accept     = 1'b0;
        div_init   = 1'b0;
        div_step   = 1'b0;
        div_zero   = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start && !flush) begin
                    accept    = 1'b1;
                    stall_req = 1'b1;
                    if (!op[1]) begin
                        next_state = MD_MUL;
                    end else if (operand_b == '0) begin
                        div_zero   = 1'b1;
                        next_state = MD_DONE;
                    end else begin
                        div_init   = 1'b1;
                        next_state = MD_DIV;
                    end
                end
            end
            MD_MUL: begin
                stall_req  = 1'b1;
                next_state = MD_DONE;
            end
            MD_DIV: begin
                stall_req = 1'b1;
                div_step  = 1'b1;
                if (div_last) next_state = MD_DONE;
            end
            MD_DONE: next_state = MD_IDLE;
            default: next_state = MD_IDLE;
        endcase
        if (flush) begin
            next_state = MD_IDLE;
            div_step   = 1'b0;
        end
    end

    // Divider is seeded with magnitudes straight from the operand inputs at the start edge.
    always_comb begin
        div_signed_in = (op == MD_OP_DIV);
        a_mag = (div_signed_in && operand_a[DATA_W-1]) ? -operand_a : operand_a;
        b_mag = (div_signed_in && operand_b[DATA_W-1]) ? -operand_b : operand_b;
    end

    mult_div_unit_div_iter #(
        .DATA_W     (DATA_W),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_iter (
        .clk        (clk),
        .rst        (rst),
        .clr        (flush),
        .init       (div_init),
        .step       (div_step),
        .dividend   (a_mag),
        .divisor    (b_mag),
        .quot_nxt_c (quot_nxt),
        .rem_nxt_c  (rem_nxt),
        .last_c     (div_last)
    );

    always_comb begin
        neg_q    = (op_q == MD_OP_DIV) && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
        neg_r    = (op_q == MD_OP_DIV) && a_q[DATA_W-1];
        quot_fix = neg_q ? -quot_nxt : quot_nxt;
        rem_fix  = neg_r ? -rem_nxt : rem_nxt;
    end

    always_comb begin
        sa = PROD_W'($signed(a_q));
        sb = PROD_W'($signed(b_q));
        ua = PROD_W'(a_q);
        ub = PROD_W'(b_q);
        if (op_q[0]) prod_c = ua * ub;
        else         prod_c = sa * sb;
    end

    // Operand latch and result registers; results only update on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            done <= 1'b0;
            hi_o <= '0;
            lo_o <= '0;
        end else begin
            done <= (next_state == MD_DONE);
            if (accept) begin
                op_q <= op;
                a_q  <= operand_a;
                b_q  <= operand_b;
            end
            if (div_zero) begin
                hi_o <= operand_a;
                lo_o <= '1;
            end else if (state == MD_MUL && !flush) begin
                hi_o <= prod_c[PROD_W-1:DATA_W];
                lo_o <= prod_c[DATA_W-1:0];
            end else if (state == MD_DIV && div_last && !flush) begin
                hi_o <= rem_fix;
                lo_o <= quot_fix;
            end
        end
    end

endmodule
